// File: rtl/vickrey_auction_seq.sv
// rtl/vickrey_auction_seq.sv - streaming second-price (Vickrey) auction engine
// Accepts 2**N serial bids over valid/ready, then presents winner, highest and price.
module vickrey_auction_seq #(
    parameter int N = 2,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bid_valid,
    input  logic [W-1:0] bid,
    output logic         bid_ready,
    output logic         result_valid,
    input  logic         result_ready,
    output logic [N-1:0] winner,
    output logic [W-1:0] highest,
    output logic [W-1:0] price
);

    typedef enum logic {
        COLLECT = 1'b0,
        RESULT  = 1'b1
    } state_t;

    localparam logic [N-1:0] LAST = '1;
    localparam logic [N-1:0] ONE  = N'(1);

    state_t       state, state_nxt;
    logic [N-1:0] cnt, cnt_nxt;
    logic [N-1:0] win, win_nxt;
    logic [W-1:0] hi, hi_nxt;
    logic [W-1:0] sec, sec_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
            cnt   <= '0;
            win   <= '0;
            hi    <= '0;
            sec   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            win   <= win_nxt;
            hi    <= hi_nxt;
            sec   <= sec_nxt;
        end
    end

    // Handshake outputs are forced low during reset so neither side sees a transfer.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        win_nxt      = win;
        hi_nxt       = hi;
        sec_nxt      = sec;
        bid_ready    = 1'b0;
        result_valid = 1'b0;
        case (state)
            COLLECT: begin
                bid_ready = !rst;
                if (bid_valid) begin
                    // Strict compares: earliest index keeps the win on ties.
                    if (bid > hi) begin
                        sec_nxt = hi;
                        hi_nxt  = bid;
                        win_nxt = cnt;
                    end else if (bid > sec) begin
                        sec_nxt = bid;
                    end
                    cnt_nxt = cnt + ONE;
                    if (cnt == LAST) begin
                        state_nxt = RESULT;
                    end
                end
            end
            RESULT: begin
                result_valid = !rst;
                if (result_ready) begin
                    state_nxt = COLLECT;
                    win_nxt   = '0;
                    hi_nxt    = '0;
                    sec_nxt   = '0;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    assign winner  = win;
    assign highest = hi;
    assign price   = sec;

endmodule

// File: tb/tb_vickrey_auction_seq.sv
// tb/tb_vickrey_auction_seq.sv - randomized self-checking bench for vickrey_auction_seq
module tb_vickrey_auction_seq;

    localparam int N = 2;
    localparam int W = 4;
    localparam int NB = 1 << N;

    logic         clk = 1'b0;
    logic         rst;
    logic         bid_valid;
    logic [W-1:0] bid;
    logic         bid_ready;
    logic         result_valid;
    logic         result_ready;
    logic [N-1:0] winner;
    logic [W-1:0] highest;
    logic [W-1:0] price;

    int vectors = 0;
    int miscompares = 0;
    int bids [NB];

    vickrey_auction_seq #(.N(N), .W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bid_valid    (bid_valid),
        .bid          (bid),
        .bid_ready    (bid_ready),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .winner       (winner),
        .highest      (highest),
        .price        (price)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: highest is the max, winner its first occurrence, price the max of the rest.
    task automatic ref_model(output int w, output int h, output int p);
        w = 0;
        h = bids[0];
        for (int i = 1; i < NB; i++)
            if (bids[i] > h) begin
                h = bids[i];
                w = i;
            end
        p = 0;
        for (int i = 0; i < NB; i++)
            if (i != w && bids[i] > p) p = bids[i];
    endtask

    // Entered and left at a negedge with rst low and the engine collecting.
    task automatic run_auction(input int gap, input int hold);
        int ew, eh, ep;
        ref_model(ew, eh, ep);
        for (int i = 0; i < NB; i++) begin
            for (int g = 0; g < gap; g++) begin
                bid_valid    = 1'b0;
                bid          = W'($urandom_range(0, 15));
                result_ready = 1'($urandom_range(0, 1));
                @(posedge clk);
                @(negedge clk);
                check("gap_bid_ready", bid_ready, 1);
                check("gap_result_valid", result_valid, 0);
            end
            result_ready = 1'($urandom_range(0, 1));
            check("collect_bid_ready", bid_ready, 1);
            check("collect_result_valid", result_valid, 0);
            bid_valid = 1'b1;
            bid       = W'(bids[i]);
            @(posedge clk);
            @(negedge clk);
        end
        bid_valid    = 1'b0;
        result_ready = 1'b0;
        check("result_valid", result_valid, 1);
        check("result_bid_ready", bid_ready, 0);
        check("winner", winner, ew);
        check("highest", highest, eh);
        check("price", price, ep);
        for (int k = 0; k < hold; k++) begin
            bid_valid = 1'b1;
            bid       = 4'd15;
            @(posedge clk);
            @(negedge clk);
            check("hold_result_valid", result_valid, 1);
            check("hold_bid_ready", bid_ready, 0);
            check("hold_winner", winner, ew);
            check("hold_highest", highest, eh);
            check("hold_price", price, ep);
        end
        bid_valid    = 1'b0;
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ready = 1'b0;
        check("post_result_valid", result_valid, 0);
        check("post_bid_ready", bid_ready, 1);
        check("post_winner", winner, 0);
        check("post_highest", highest, 0);
        check("post_price", price, 0);
    endtask

    initial begin
        rst          = 1'b1;
        bid_valid    = 1'b1;
        bid          = 4'd9;
        result_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bid_ready", bid_ready, 0);
        check("rst_result_valid", result_valid, 0);
        bid_valid    = 1'b0;
        result_ready = 1'b0;
        rst          = 1'b0;
        #1;
        check("init_winner", winner, 0);
        check("init_highest", highest, 0);
        check("init_price", price, 0);
        check("init_bid_ready", bid_ready, 1);

        bids = '{3, 9, 5, 7};     run_auction(0, 0);
        bids = '{6, 6, 2, 1};     run_auction(0, 0);
        bids = '{0, 0, 0, 0};     run_auction(0, 0);
        bids = '{15, 15, 15, 15}; run_auction(0, 0);
        bids = '{2, 11, 4, 8};    run_auction(2, 5);

        // Abandon an auction partway through with a one-cycle reset.
        bids = '{14, 13, 0, 0};
        for (int i = 0; i < 2; i++) begin
            bid_valid = 1'b1;
            bid       = W'(bids[i]);
            @(posedge clk);
            @(negedge clk);
        end
        bid_valid = 1'b0;
        rst       = 1'b1;
        #1;
        check("midrst_bid_ready", bid_ready, 0);
        check("midrst_result_valid", result_valid, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_highest", highest, 0);
        check("midrst_price", price, 0);
        check("midrst_winner", winner, 0);
        bids = '{1, 2, 3, 4};     run_auction(0, 0);

        bids = '{5, 1, 1, 1};     run_auction(0, 0);
        bids = '{1, 1, 1, 12};    run_auction(0, 0);

        for (int a = 0; a < 40; a++) begin
            for (int i = 0; i < NB; i++)
                bids[i] = (a % 3 == 0) ? 5 * $urandom_range(0, 3) : $urandom_range(0, 15);
            run_auction($urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/vickrey_auction_seq.md
# vickrey_auction_seq

Sequential, handshake-driven sealed-bid auction engine that accepts `2**N` bids serially, one per cycle. It reports the winning bidder index, the highest bid and the second-highest bid, which is the clearing price for a second-price (Vickrey) settlement. It is the streaming counterpart of the parallel tournament-tree auction: the same bidder count and width parameters, but bids arrive over a valid/ready channel instead of a flat bus. It sits between a bid source and a settlement consumer, each connected by its own valid/ready handshake.

## Interface
- `N`, default 2: log2 of bidder count; bids per auction = `2**N`; N >= 1.
- `W`, default 2: bid width in bits, unsigned.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `bid_valid`  in  1  bid source presents a bid.
- `bid`  in  W  unsigned bid value; bidder index = arrival order within the auction.
- `bid_ready`  out  1  engine accepts a bid this cycle.
- `result_valid`  out  1  result outputs valid.
- `result_ready`  in  1  consumer accepts result.
- `winner`  out  N  index (0..2**N-1) of the highest bidder.
- `highest`  out  W  highest bid value.
- `price`  out  W  second-highest bid value (clearing price).

## Operation
- Two states, encoded in a registered state bit:
  - COLLECT: `bid_ready`=1, `result_valid`=0.
  - RESULT: `bid_ready`=0, `result_valid`=1.
- Internal registers:
  - `cnt` (N bits): index of the next bid.
  - `hi` (W), `sec` (W), `win` (N).
- Bid acceptance: a bid is accepted when `bid_valid && bid_ready` at a clock edge. On acceptance:
  - If `bid > hi`: `sec<=hi`, `hi<=bid`, `win<=cnt`.
  - Else if `bid > sec`: `sec<=bid`.
  - `cnt<=cnt+1`.
- Ties: strict greater-than comparison, so the lowest index wins among equal highest bids. An equal second bid sets `price` = `highest`.
- Last bid: accepting the bid with `cnt == 2**N-1` moves the state to RESULT. `cnt` wraps to 0.
- RESULT:
  - `winner`/`highest`/`price` drive `win`/`hi`/`sec` and hold stable while `result_valid`=1.
  - On `result_valid && result_ready`: next state is COLLECT; `hi`, `sec` and `win` clear to 0.
- `bid_valid` is ignored outside COLLECT. `result_ready` is ignored outside RESULT.
- Unsigned arithmetic throughout. No overflow is possible because only comparisons are performed.
- An all-zero auction yields `winner`=0, `highest`=0, `price`=0.

## Timing
- Reset:
  - While `rst`=1, `bid_ready`=0 and `result_valid`=0.
  - At the edge with `rst`=1: state<=COLLECT, `cnt`<=0, `hi`/`sec`/`win`<=0.
  - Outputs `winner`, `highest` and `price` read 0 after reset.
- First bid is accepted at the first edge with `rst`=0, `bid_valid`=1.
- Throughput is one bid per cycle. Gaps in `bid_valid` stall `cnt` with no state change.
- Latency: `result_valid` rises the cycle after the edge that accepts bid `2**N-1`, i.e. 1 cycle.
- Result handshake: `result_valid` stays high until the handshake edge. `bid_ready` rises the following cycle, so a new auction's bid 0 can be accepted one cycle after the result handshake.
- `rst` asserted mid-collection or mid-result discards the auction in progress. The next auction restarts at index 0.
- Simultaneous `rst` and handshake: `rst` wins.

## Test plan
All scenarios use N=2, W=4.
- Basic auction: bids 3,9,5,7 back-to-back, `result_ready`=1 -> `result_valid` 1 cycle after the 4th accept; `winner`=1, `highest`=9, `price`=7. `bid_ready`=1 again the cycle after the handshake.
- Tie: bids 6,6,2,1 -> `winner`=0, `highest`=6, `price`=6.
- All zero / all max:
  - Bids 0,0,0,0 -> `winner`=0, `highest`=0, `price`=0.
  - Bids 15,15,15,15 -> `winner`=0, `highest`=15, `price`=15.
- Backpressure and gaps:
  - Bids 2,11,4,8 with `bid_valid` low for 2 cycles between each bid -> `winner`=1, `price`=8.
  - Hold `result_ready`=0 for 5 cycles -> outputs stable, `bid_ready`=0, and a `bid_valid`=1 of 15 presented meanwhile is ignored.
- Reset mid-operation: accept 14,13, pulse `rst` for 1 cycle, then bids 1,2,3,4 -> `winner`=3, `highest`=4, `price`=3.
- Back-to-back auctions: 5,1,1,1 then, one cycle after the handshake, 1,1,1,12 -> first result `winner`=0, `price`=1; second result `winner`=3, `price`=1.
